// File: rtl/inv_sbox_pipe.sv
// Three-stage pipelined AES inverse S-box (InvSubBytes) built on the composite field GF((2^4)^2),
// with valid/ready handshaking and a skid-free, bubble-collapsing stall scheme.
module inv_sbox_pipe (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic [7:0] data_i,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] data_o
);

  localparam int DATA_W = 8;

  // GF(4) = GF(2)[z]/(z^2+z+1); GF(16) = GF(4)[y]/(y^2+y+phi), phi = z; GF(256) uses x^2+x+lambda
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    logic hh;
    hh = a[1] & b[1];
    return {hh ^ (a[1] & b[0]) ^ (a[0] & b[1]), hh ^ (a[0] & b[0])};
  endfunction

  function automatic logic [1:0] gf4_sq(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction

  function automatic logic [1:0] gf4_mulphi(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] hh;
    logic [1:0] hi;
    logic [1:0] lo;
    hh = gf4_mul(a[3:2], b[3:2]);
    hi = hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]);
    lo = gf4_mulphi(hh) ^ gf4_mul(a[1:0], b[1:0]);
    return {hi, lo};
  endfunction

  function automatic logic [3:0] gf16_sq(input logic [3:0] q);
    return {q[3], q[3] ^ q[2], q[2] ^ q[1], q[3] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [3:0] gf16_mullambda(input logic [3:0] q);
    return {q[2] ^ q[0], q[3] ^ q[2] ^ q[1] ^ q[0], q[3], q[2]};
  endfunction

  // Inverse via the GF(4) norm; GF(4) inverse equals squaring, so 0 maps to 0 naturally
  function automatic logic [3:0] gf16_inv(input logic [3:0] q);
    logic [1:0] e;
    logic [1:0] ei;
    e  = gf4_mulphi(gf4_sq(q[3:2])) ^ gf4_mul(q[3:2], q[1:0]) ^ gf4_sq(q[1:0]);
    ei = gf4_sq(e);
    return {gf4_mul(q[3:2], ei), gf4_mul(q[3:2] ^ q[1:0], ei)};
  endfunction

  function automatic logic [DATA_W-1:0] inv_affine(input logic [DATA_W-1:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [DATA_W-1:0] iso(input logic [DATA_W-1:0] q);
    return {q[7] ^ q[5],
            q[7] ^ q[6] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[7] ^ q[5] ^ q[3] ^ q[2],
            q[7] ^ q[5] ^ q[3] ^ q[2] ^ q[1],
            q[7] ^ q[6] ^ q[2] ^ q[1],
            q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[6] ^ q[4] ^ q[1],
            q[6] ^ q[1] ^ q[0]};
  endfunction

  function automatic logic [DATA_W-1:0] iso_inv(input logic [DATA_W-1:0] q);
    return {q[7] ^ q[6] ^ q[5] ^ q[1],
            q[6] ^ q[2],
            q[6] ^ q[5] ^ q[1],
            q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[1],
            q[5] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[7] ^ q[4] ^ q[3] ^ q[2] ^ q[1],
            q[5] ^ q[4],
            q[6] ^ q[5] ^ q[4] ^ q[2] ^ q[0]};
  endfunction

  logic        vld_p0, vld_p1, vld_p2;
  logic        adv_p0, adv_p1, adv_p2;
  logic [3:0]  ah_p0, al_p0, sum_p0, sq_p0;
  logic [3:0]  ah_p1, sum_p1, dinv_p1;
  logic [DATA_W-1:0] a_iso;
  logic [3:0]  d_p0;

  assign adv_p2  = ~vld_p2 | ready_i;
  assign adv_p1  = ~vld_p1 | adv_p2;
  assign adv_p0  = ~vld_p0 | adv_p1;
  assign ready_o = ~rst_i & adv_p0;
  assign valid_o = vld_p2;

  assign a_iso = iso(inv_affine(data_i));
  assign d_p0  = sq_p0 ^ gf16_mul(sum_p0, al_p0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p0) vld_p0 <= valid_i;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // Stage 1: inverse affine, isomorphic map, sum and lambda-scaled square
  always_ff @(posedge clk_i) begin
    if (adv_p0 && valid_i) begin
      ah_p0  <= a_iso[7:4];
      al_p0  <= a_iso[3:0];
      sum_p0 <= a_iso[7:4] ^ a_iso[3:0];
      sq_p0  <= gf16_mullambda(gf16_sq(a_iso[7:4]));
    end
  end

  // Stage 2: norm and GF(16) inverse
  always_ff @(posedge clk_i) begin
    if (adv_p1 && vld_p0) begin
      ah_p1   <= ah_p0;
      sum_p1  <= sum_p0;
      dinv_p1 <= gf16_inv(d_p0);
    end
  end

  // Stage 3: GF(16) products and inverse isomorphic map
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= '0;
    end else if (adv_p2 && vld_p1) begin
      data_o <= iso_inv({gf16_mul(ah_p1, dinv_p1), gf16_mul(sum_p1, dinv_p1)});
    end
  end

endmodule

// File: tb/tb_inv_sbox_pipe.sv
// Bench for inv_sbox_pipe: directed handshake scenarios plus randomized exhaustive sweep,
// scored against an inverse S-box derived from plain GF(2^8) arithmetic.
module tb_inv_sbox_pipe;

  logic       clk;
  logic       rst_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;

  int checks = 0;
  int errors = 0;
  int nemit  = 0;
  logic [7:0] tbl [256];
  logic [7:0] q [$];

  inv_sbox_pipe dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    return 8'h00;
  endfunction

  function automatic logic [7:0] invaff(input logic [7:0] a);
    logic [7:0] b;
    logic [7:0] c;
    c = 8'h05;
    for (int i = 0; i < 8; i++)
      b[i] = a[(i + 2) % 8] ^ a[(i + 5) % 8] ^ a[(i + 7) % 8] ^ c[i];
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score transfers just before the edge, return at edge+1 with outputs settled.
  task automatic tick(output bit acc);
    logic       held;
    logic [7:0] dprev;
    #2;
    acc   = valid_i && ready_o && !rst_i;
    held  = valid_o && !ready_i && !rst_i;
    dprev = data_o;
    if (rst_i) begin
      q.delete();
    end else begin
      if (valid_o && ready_i) begin
        nemit++;
        if (q.size() == 0) chk("spurious_out", 32'(valid_o), 32'd0);
        else chk("order_data", 32'(data_o), 32'(q.pop_front()));
      end
      if (acc) q.push_back(tbl[data_i]);
    end
    @(posedge clk);
    #1;
    if (held && !rst_i) begin
      chk("stall_valid", 32'(valid_o), 32'd1);
      chk("stall_data", 32'(data_o), 32'(dprev));
    end
  endtask

  initial begin
    bit acc;
    int idx;
    int cyc;
    int e0;
    logic [7:0] s_in  [4];
    logic [7:0] s_exp [4];
    logic [7:0] bp    [5];

    for (int v = 0; v < 256; v++) tbl[v] = ginv(invaff(8'(v)));
    s_in  = '{8'h63, 8'h7C, 8'hED, 8'h16};
    s_exp = '{8'h00, 8'h01, 8'h53, 8'hFF};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; data_i = 8'h00;
    tick(acc);
    tick(acc);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'h00);
    chk("rst_ready_o", 32'(ready_o), 32'd0);
    rst_i = 1'b0; ready_i = 1'b1;
    #1;
    chk("ready_after_rst", 32'(ready_o), 32'd1);

    // single byte 0x00 -> 0x52, three cycles later, one cycle wide
    valid_i = 1'b1; data_i = 8'h00;
    tick(acc);
    chk("single_acc", 32'(acc), 32'd1);
    valid_i = 1'b0; data_i = 8'hA5;
    chk("single_c1", 32'(valid_o), 32'd0);
    tick(acc);
    chk("single_c2", 32'(valid_o), 32'd0);
    tick(acc);
    chk("single_c3_valid", 32'(valid_o), 32'd1);
    chk("single_c3_data", 32'(data_o), 32'h52);
    tick(acc);
    chk("single_c4", 32'(valid_o), 32'd0);

    // back-to-back stream
    for (int c = 0; c < 8; c++) begin
      valid_i = (c < 4);
      data_i  = (c < 4) ? s_in[c] : 8'h00;
      tick(acc);
      if (c + 1 >= 3 && c + 1 <= 6) begin
        chk("stream_valid", 32'(valid_o), 32'd1);
        chk("stream_data", 32'(data_o), 32'(s_exp[c - 2]));
      end else begin
        chk("stream_idle", 32'(valid_o), 32'd0);
      end
    end

    // backpressure: 5 bytes offered with ready_i low
    bp = '{8'h3A, 8'hC4, 8'h09, 8'hF0, 8'h63};
    ready_i = 1'b0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      valid_i = 1'b1; data_i = bp[idx];
      tick(acc);
      if (acc) idx++;
    end
    chk("bp_accepted", 32'(idx), 32'd3);
    chk("bp_ready_low", 32'(ready_o), 32'd0);
    chk("bp_valid_o", 32'(valid_o), 32'd1);
    chk("bp_head_data", 32'(data_o), 32'(tbl[bp[0]]));
    tick(acc);
    tick(acc);
    e0 = nemit; ready_i = 1'b1; cyc = 0;
    while ((idx < 5 || q.size() != 0) && cyc < 100) begin
      valid_i = (idx < 5); data_i = (idx < 5) ? bp[idx] : 8'h00;
      tick(acc);
      if (acc) idx++;
      cyc++;
    end
    chk("bp_all_out", 32'(nemit - e0), 32'd5);

    // full pipeline, accept and emit every cycle
    valid_i = 1'b1; ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data_i = 8'($urandom_range(0, 255));
      tick(acc);
    end
    for (int c = 0; c < 10; c++) begin
      data_i = 8'($urandom_range(0, 255));
      chk("full_ready_o", 32'(ready_o), 32'd1);
      chk("full_valid_o", 32'(valid_o), 32'd1);
      tick(acc);
    end
    valid_i = 1'b0;
    for (int c = 0; c < 4; c++) tick(acc);
    chk("full_drained", 32'(q.size()), 32'd0);

    // reset with 3 bytes in flight
    ready_i = 1'b0; valid_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      data_i = 8'(8'h20 + c);
      tick(acc);
    end
    rst_i = 1'b1; valid_i = 1'b0;
    tick(acc);
    chk("midrst_valid_o", 32'(valid_o), 32'd0);
    chk("midrst_data_o", 32'(data_o), 32'h00);
    chk("midrst_ready_o", 32'(ready_o), 32'd0);
    rst_i = 1'b0; ready_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(acc);
      chk("postrst_no_stale", 32'(valid_o), 32'd0);
    end

    // all 256 inputs, random valid/ready
    idx = 0; cyc = 0; e0 = nemit;
    while ((idx < 256 || q.size() != 0) && cyc < 20000) begin
      valid_i = (idx < 256) && ($urandom_range(0, 3) != 0);
      data_i  = (idx < 256) ? 8'(idx) : 8'($urandom_range(0, 255));
      ready_i = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc) idx++;
      cyc++;
    end
    chk("exh_inputs", 32'(idx), 32'd256);
    chk("exh_outputs", 32'(nemit - e0), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_sbox_pipe.md
INV_SBOX_PIPE -- requirements
Module: inv_sbox_pipe

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  upstream byte on data_i is valid.
REQ-005 ready_o  output  1  block accepts data_i this cycle.
REQ-006 data_i  input  8  ciphertext-domain byte for InvSubBytes.
REQ-007 valid_o  output  1  data_o holds a valid result.
REQ-008 ready_i  input  1  downstream accepts data_o this cycle.
REQ-009 data_o  output  8  InvSubBytes(data_i) per FIPS-197.
REQ-010 The clock and reset SHALL be one clock, clk_i, and a synchronous, active-high reset, rst_i; no other clock or reset exists.

Function
REQ-011 The block SHALL compute the FIPS-197 inverse S-box for every input byte, bit-exact with the standard table.
REQ-012 The computation SHALL use composite field GF((2^4)^2), with all GF(16) additions as bitwise XOR of nibbles.
REQ-013 The computation SHALL be split across three register stages:
- S1: inverse affine transform, isomorphic map to GF((2^4)^2), GF(16) sum, square and scale terms.
- S2: GF(16) multiplicative inverse.
- S3: GF(16) multiplications, inverse isomorphic map.
REQ-014 GF(16) inverse of 0 SHALL be 0, so input 0x63 yields 0x00.
REQ-015 Latency SHALL be exactly 3 cycles from a transfer into the block (valid_i&&ready_o) to valid_o, when no stall occurs.
REQ-016 Throughput SHALL be one byte per cycle while ready_i stays high.
REQ-017 Each stage SHALL hold a valid bit; stage k loads when it is empty or when its content moves to stage k+1 (or out of the block, for S3) in the same cycle.
REQ-018 ready_o SHALL be high iff S1 is empty or S1 advances this cycle; ready_o is combinational from stage valids and ready_i only, never from valid_i.
REQ-019 Output transfer: the result leaves the block when valid_o&&ready_i; valid_o and data_o SHALL stay stable while valid_o is high and ready_i is low.
REQ-020 Full pipeline (3 valid) with ready_i low SHALL drive ready_o low; no byte is dropped or overwritten.
REQ-021 Full pipeline with ready_i high and valid_i high SHALL accept one input and emit one output in the same cycle.
REQ-022 Bubbles SHALL collapse: with ready_i low, an empty downstream stage still loads from its upstream stage.
REQ-023 Results SHALL leave in input order; no reordering and no duplication.
REQ-024 data_i SHALL be ignored when valid_i is low or ready_o is low.

Reset
REQ-025 While rst_i is high, all stage valid bits SHALL clear at the clock edge; valid_o = 0 and data_o = 0x00 on the following cycle.
REQ-026 While rst_i is high, ready_o SHALL be low; it rises in the first cycle after rst_i deasserts.
REQ-027 Reset mid-operation SHALL discard all in-flight bytes; none appears on data_o after reset.
REQ-028 Datapath registers other than data_o need no reset value.

Verification
REQ-029 Single byte: data_i=0x00 with valid_i=1, ready_i=1 -> data_o=0x52 and valid_o=1 exactly 3 cycles later, one cycle wide.
REQ-030 Back-to-back stream: 0x63, 0x7C, 0xED, 0x16 on consecutive cycles with ready_i=1 -> outputs 0x00, 0x01, 0x53, 0xFF on consecutive cycles starting at cycle 3.
REQ-031 Backpressure: stream 5 bytes with ready_i=0 -> exactly 3 are accepted, ready_o falls, data_o is held; after ready_i=1 all 5 results emerge in order with no loss.
REQ-032 Simultaneous events: pipeline full, valid_i=1, ready_i=1 -> one accept and one emit in the same cycle for 10 consecutive cycles.
REQ-033 Reset mid-stream: assert rst_i with 3 bytes in flight -> valid_o=0 and data_o=0x00 the next cycle; no stale output after release.
REQ-034 Exhaustive: all 256 inputs with random valid_i/ready_i -> every output matches the FIPS-197 inverse S-box table, in order.
